// File: rtl/serial_fadder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | serial_fadder : digit-serial add/sub, LSB-first, registered carry    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module serial_fadder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             SUB,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT,
  output logic             OVF,
  output logic             BUSY,
  output logic             DONE
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic [DIGIT:0]   dsum;
  logic             c_into_msb;
  logic [WIDTH-1:0] res_shift;

  // One DIGIT-wide slice of the carry chain per clock.
  always_comb begin
    dsum = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
         + {{DIGIT{1'b0}}, carry_q};
    c_into_msb = dsum[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1];
  end

  generate
    if (DIGIT == WIDTH) begin : g_single_digit
      assign res_shift = dsum[DIGIT-1:0];
    end else begin : g_multi_digit
      assign res_shift = {dsum[DIGIT-1:0], res_q[WIDTH-1:DIGIT]};
    end
  endgenerate

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (START) state_d = S_RUN;
      S_RUN:   if (cnt_q == LAST) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Subtraction is fully encoded by inverting B and seeding the carry,
  // so the operation type need not be kept past acceptance.
  always_comb begin
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    if (state_q == S_IDLE) begin
      if (START) begin
        a_d     = A;
        b_d     = SUB ? ~B : B;
        carry_d = CIN ^ SUB;
        cnt_d   = '0;
      end
    end else begin
      a_d     = a_q >> DIGIT;
      b_d     = b_q >> DIGIT;
      res_d   = res_shift;
      carry_d = dsum[DIGIT];
      cnt_d   = cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        sum_d  = res_shift;
        cout_d = dsum[DIGIT];
        ovf_d  = c_into_msb ^ dsum[DIGIT];
        done_d = 1'b1;
      end
    end
  end

  // BUSY covers the run cycles after the first digit has been consumed.
  always_comb begin
    SUM  = sum_q;
    COUT = cout_q;
    OVF  = ovf_q;
    DONE = done_q;
    BUSY = (state_q == S_RUN) && (cnt_q != '0);
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_fadder.sv
`default_nettype none
// Directed bench for serial_fadder: main DUT at DIGIT=1, sweep DUTs at DIGIT 4/2/8.
module tb_serial_fadder;

  logic       clk;
  logic       rst;
  logic       start_m, start_x;
  logic       sub, cin;
  logic [7:0] a, b;

  logic [7:0] sum_m;
  logic       cout_m, ovf_m, busy_m, done_m;

  logic [7:0] xs_sum  [3];
  logic       xs_cout [3];
  logic       xs_ovf  [3];
  logic       xs_busy [3];
  logic       xs_done [3];

  int n_checks = 0;
  int n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  serial_fadder #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .CLK(clk), .RST(rst), .START(start_m), .SUB(sub), .A(a), .B(b), .CIN(cin),
    .SUM(sum_m), .COUT(cout_m), .OVF(ovf_m), .BUSY(busy_m), .DONE(done_m));

  serial_fadder #(.WIDTH(8), .DIGIT(4)) u_d4 (
    .CLK(clk), .RST(rst), .START(start_x), .SUB(sub), .A(a), .B(b), .CIN(cin),
    .SUM(xs_sum[0]), .COUT(xs_cout[0]), .OVF(xs_ovf[0]), .BUSY(xs_busy[0]), .DONE(xs_done[0]));

  serial_fadder #(.WIDTH(8), .DIGIT(2)) u_d2 (
    .CLK(clk), .RST(rst), .START(start_x), .SUB(sub), .A(a), .B(b), .CIN(cin),
    .SUM(xs_sum[1]), .COUT(xs_cout[1]), .OVF(xs_ovf[1]), .BUSY(xs_busy[1]), .DONE(xs_done[1]));

  serial_fadder #(.WIDTH(8), .DIGIT(8)) u_d8 (
    .CLK(clk), .RST(rst), .START(start_x), .SUB(sub), .A(a), .B(b), .CIN(cin),
    .SUM(xs_sum[2]), .COUT(xs_cout[2]), .OVF(xs_ovf[2]), .BUSY(xs_busy[2]), .DONE(xs_done[2]));

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference: {ovf, cout, sum} for an 8-bit add/subtract.
  function automatic logic [9:0] ref_fadd(input logic [7:0] ia, input logic [7:0] ib,
                                          input logic isub, input logic icin);
    logic [7:0] bb;
    logic [8:0] full;
    logic       ov;
    bb   = isub ? ~ib : ib;
    full = {1'b0, ia} + {1'b0, bb} + {8'd0, icin ^ isub};
    ov   = (ia[7] == bb[7]) && (full[7] != ia[7]);
    return {ov, full[8], full[7:0]};
  endfunction

  task automatic wait_done_m(output int n);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done_m) begin
        n = i;
        break;
      end
    end
  endtask

  // Returns with the clock #1 past the DONE edge (DONE still high).
  task automatic run_m(input logic [7:0] ia, input logic [7:0] ib, input logic isub,
                       input logic icin, output int lat, output int busy_cnt);
    @(negedge clk);
    a = ia; b = ib; sub = isub; cin = icin; start_m = 1'b1;
    @(posedge clk); #1;
    start_m = 1'b0;
    lat = 0;
    busy_cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (busy_m) busy_cnt++;
      if (done_m) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic run_x(input logic [7:0] ia, input logic [7:0] ib, input logic isub,
                       input logic icin);
    int         lat [3];
    int         exp_lat [3];
    logic [9:0] exp;
    exp_lat[0] = 2; exp_lat[1] = 4; exp_lat[2] = 1;
    for (int k = 0; k < 3; k++) lat[k] = 0;
    @(negedge clk);
    a = ia; b = ib; sub = isub; cin = icin; start_x = 1'b1;
    @(posedge clk); #1;
    start_x = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++)
        if (xs_done[k] && lat[k] == 0) lat[k] = i;
    end
    exp = ref_fadd(ia, ib, isub, icin);
    for (int k = 0; k < 3; k++) begin
      check("sweep_latency", lat[k], exp_lat[k]);
      check("sweep_sum", {24'd0, xs_sum[k]}, {24'd0, exp[7:0]});
      check("sweep_cout_ovf", {30'd0, xs_ovf[k], xs_cout[k]}, {30'd0, exp[9], exp[8]});
    end
  endtask

  initial begin : main
    int lat, bcnt, nd;
    rst = 1'b1; start_m = 1'b0; start_x = 1'b0;
    a = '0; b = '0; sub = 1'b0; cin = 1'b0;
    #1;
    check("reset_outputs", {21'd0, sum_m, cout_m, ovf_m, busy_m, done_m}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // 1: 0x7F + 0x01 overflows into the sign bit
    run_m(8'h7F, 8'h01, 1'b0, 1'b0, lat, bcnt);
    check("t1_latency", lat, 8);
    check("t1_busy_cycles", bcnt, 7);
    check("t1_sum", {24'd0, sum_m}, 32'h80);
    check("t1_cout_ovf", {30'd0, cout_m, ovf_m}, {30'd0, 1'b0, 1'b1});
    @(posedge clk); #1;
    check("t1_done_one_cycle", {31'd0, done_m}, 32'd0);

    // 2
    run_m(8'hFF, 8'h01, 1'b0, 1'b1, lat, bcnt);
    check("t2_add_sum", {24'd0, sum_m}, 32'h01);
    check("t2_add_cout_ovf", {30'd0, cout_m, ovf_m}, {30'd0, 1'b1, 1'b0});
    run_m(8'h05, 8'h07, 1'b1, 1'b0, lat, bcnt);
    check("t2_sub_sum", {24'd0, sum_m}, 32'hFE);
    check("t2_sub_cout_ovf", {30'd0, cout_m, ovf_m}, {30'd0, 1'b0, 1'b0});

    // 3
    run_m(8'h80, 8'h01, 1'b1, 1'b0, lat, bcnt);
    check("t3_sub_sum", {24'd0, sum_m}, 32'h7F);
    check("t3_sub_cout_ovf", {30'd0, cout_m, ovf_m}, {30'd0, 1'b1, 1'b1});
    run_m(8'h10, 8'h00, 1'b1, 1'b1, lat, bcnt);
    check("t3_borrow_sum", {24'd0, sum_m}, 32'h0F);
    check("t3_borrow_cout", {31'd0, cout_m}, 32'd1);

    // 4: START during RUN is ignored; START in the DONE cycle is accepted
    @(negedge clk);
    a = 8'h12; b = 8'h34; sub = 1'b0; cin = 1'b0; start_m = 1'b1;
    @(posedge clk); #1;
    start_m = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    a = 8'h00; b = 8'h00; start_m = 1'b1;
    @(posedge clk); #1;
    start_m = 1'b0;
    wait_done_m(lat);
    check("t4_latency", lat + 4, 8);
    check("t4_sum", {24'd0, sum_m}, 32'h46);
    a = 8'h01; b = 8'h02; start_m = 1'b1;
    @(posedge clk); #1;
    start_m = 1'b0;
    check("t4_single_done", {31'd0, done_m}, 32'd0);
    wait_done_m(lat);
    check("t4_b2b_spacing", lat + 1, 9);
    check("t4_b2b_sum", {24'd0, sum_m}, 32'h03);

    // 5: asynchronous reset mid-run
    @(negedge clk);
    a = 8'h55; b = 8'h11; start_m = 1'b1;
    @(posedge clk); #1;
    start_m = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    check("t5_async_reset", {21'd0, sum_m, cout_m, ovf_m, busy_m, done_m}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    repeat (12) begin @(posedge clk); #1; if (done_m) nd++; end
    check("t5_no_done", nd, 0);
    run_m(8'h01, 8'h01, 1'b0, 1'b0, lat, bcnt);
    check("t5_latency", lat, 8);
    check("t5_sum", {24'd0, sum_m}, 32'h02);

    // 6: DIGIT=4, signed -85 + -51 overflows
    run_x(8'hAB, 8'hCD, 1'b0, 1'b0);
    check("t6_d4_sum", {24'd0, xs_sum[0]}, 32'h78);
    check("t6_d4_cout_ovf", {30'd0, xs_cout[0], xs_ovf[0]}, {30'd0, 1'b1, 1'b1});
    run_x(8'h80, 8'h01, 1'b1, 1'b0);
    run_x(8'h7F, 8'h7F, 1'b0, 1'b1);
    for (int v = 0; v < 8; v++)
      run_x(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
